// File: rtl/setpoint_stream_rx.sv
// setpoint_stream_rx: double-buffered setpoint frame receiver.
// Optional frame-timeout watchdog: define SETPOINT_RX_WATCHDOG_EN.
module setpoint_stream_rx #(
  parameter  int RESULT_COUNT    = 32,
  parameter  int WATCHDOG_CYCLES = 100000,
  localparam int AW              = $clog2(RESULT_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SETPOINT_TVALID,
  input  logic          SETPOINT_TLAST,
  input  logic [31:0]   SETPOINT_TDATA,
  input  logic [AW-1:0] readAddress,
  output logic [31:0]   readData,
  input  logic          statusClearStrobe,
  output logic          frameToggle,
  output logic [15:0]   frameCount,
  output logic [31:0]   status
);

  typedef enum logic {
    ST_RECEIVE,
    ST_DISCARD
  } state_t;

  localparam bit ADDR_FULL = (RESULT_COUNT == (1 << AW));

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_active;
  logic          r_toggle;
  logic          r_valid;
  logic          r_missing;
  logic          r_unexp;
  logic [15:0]   r_count;
  logic [31:0]   r_rd;
  logic [31:0]   r_bank0 [RESULT_COUNT];
  logic [31:0]   r_bank1 [RESULT_COUNT];

  logic          w_rx;
  logic          w_last_idx;
  logic          w_commit;
  logic          w_unexp;
  logic          w_miss;
  logic          w_addr_ok;
  logic          w_stale;
  logic [31:0]   w_rd_word;

  assign w_rx       = SETPOINT_TVALID && (r_state == ST_RECEIVE);
  assign w_last_idx = (r_idx == AW'(RESULT_COUNT - 1));
  assign w_commit   = w_rx && SETPOINT_TLAST && w_last_idx;
  assign w_unexp    = w_rx && SETPOINT_TLAST && !w_last_idx;
  assign w_miss     = w_rx && !SETPOINT_TLAST && w_last_idx;

  assign w_addr_ok = ADDR_FULL ||
    ({{(32-AW){1'b0}}, readAddress} < 32'(RESULT_COUNT));

  assign w_rd_word = r_active ? r_bank1[readAddress]
                              : r_bank0[readAddress];

  // Beats land in the bank that is not being read back.
  always_ff @(posedge clk) begin
    if (w_rx) begin
      if (r_active) r_bank0[r_idx] <= SETPOINT_TDATA;
      else          r_bank1[r_idx] <= SETPOINT_TDATA;
    end
  end

  // Frame FSM: beat index, bank flip, frame counters, sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RECEIVE;
      r_idx     <= '0;
      r_active  <= 1'b0;
      r_toggle  <= 1'b0;
      r_valid   <= 1'b0;
      r_missing <= 1'b0;
      r_unexp   <= 1'b0;
      r_count   <= '0;
    end else begin
      if (SETPOINT_TVALID) begin
        unique case (r_state)
          ST_RECEIVE: begin
            if (SETPOINT_TLAST) begin
              r_idx <= '0;
              if (w_last_idx) begin
                r_active <= ~r_active;
                r_toggle <= ~r_toggle;
                r_count  <= r_count + 16'd1;
                r_valid  <= 1'b1;
              end
            end else if (w_last_idx) begin
              r_idx   <= '0;
              r_state <= ST_DISCARD;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
          ST_DISCARD: begin
            if (SETPOINT_TLAST) begin
              r_idx   <= '0;
              r_state <= ST_RECEIVE;
            end
          end
          default: r_state <= ST_RECEIVE;
        endcase
      end
      if (w_unexp)                r_unexp <= 1'b1;
      else if (statusClearStrobe) r_unexp <= 1'b0;
      if (w_miss)                 r_missing <= 1'b1;
      else if (statusClearStrobe) r_missing <= 1'b0;
    end
  end

  // Registered readback from the active bank, masked until a frame lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd <= '0;
    else        r_rd <= (r_valid && w_addr_ok) ? w_rd_word : '0;
  end

`ifdef SETPOINT_RX_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WW-1:0] r_wd;

  // Cycles since the last commit, saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_wd <= '0;
    else if (w_commit)                      r_wd <= '0;
    else if (r_wd != WW'(WATCHDOG_CYCLES)) r_wd <= r_wd + WW'(1);
  end

  assign w_stale = (r_wd == WW'(WATCHDOG_CYCLES));
`else
  assign w_stale = 1'b0;
`endif

  assign readData    = r_rd;
  assign frameToggle = r_toggle;
  assign frameCount  = r_count;
  assign status      = {28'b0, w_stale, r_valid, r_missing, r_unexp};

endmodule

// File: tb/tb_setpoint_stream_rx.sv
// tb_setpoint_stream_rx: scoreboard bench for setpoint_stream_rx.
// Directed frames; monitors pop expected values as outputs appear.
module tb_setpoint_stream_rx;

  localparam int RC = 4;
  localparam int WD = 100;

`ifdef SETPOINT_RX_WATCHDOG_EN
  localparam logic [31:0] STALE_ST = 32'hC;
`else
  localparam logic [31:0] STALE_ST = 32'h4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic [1:0]  raddr = '0;
  logic [31:0] rdata;
  logic        clr = 1'b0;
  logic        ftog;
  logic [15:0] fcnt;
  logic [31:0] status;

  always #5 clk = ~clk;

  setpoint_stream_rx #(
    .RESULT_COUNT(RC),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SETPOINT_TVALID(tvalid),
    .SETPOINT_TLAST(tlast),
    .SETPOINT_TDATA(tdata),
    .readAddress(raddr),
    .readData(rdata),
    .statusClearStrobe(clr),
    .frameToggle(ftog),
    .frameCount(fcnt),
    .status(status)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        tog;
  } cexp_t;

  exp_t  rdq[$];
  exp_t  stq[$];
  cexp_t cq[$];

  int   errors = 0;
  int   checks = 0;
  logic chk_rd = 1'b0;
  logic chk_st = 1'b0;
  logic prev_tog = 1'b0;

  // Readback / status monitor: compares one edge after a request.
  always @(posedge clk) begin
    bit   rdf;
    bit   stf;
    exp_t e;
    rdf = chk_rd;
    stf = chk_st;
    #1;
    if (rdf) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL rd_queue_empty: readData=%h", rdata);
      end else begin
        e = rdq.pop_front();
        if (rdata !== e.val) begin
          errors++;
          $display("FAIL %s: readData got %h want %h",
                   e.name, rdata, e.val);
        end
      end
    end
    if (stf) begin
      checks++;
      if (stq.size() == 0) begin
        errors++;
        $display("FAIL st_queue_empty: status=%h", status);
      end else begin
        e = stq.pop_front();
        if (status !== e.val) begin
          errors++;
          $display("FAIL %s: status got %h want %h",
                   e.name, status, e.val);
        end
      end
    end
  end

  // Commit monitor: every frameToggle change must match a queued commit.
  always @(posedge clk) begin
    cexp_t c;
    #1;
    if (!rst_n) begin
      prev_tog = ftog;
    end else if (ftog !== prev_tog) begin
      prev_tog = ftog;
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: frameCount got %0d want none",
                 fcnt);
      end else begin
        c = cq.pop_front();
        if (fcnt !== c.cnt || ftog !== c.tog) begin
          errors++;
          $display("FAIL %s: count/toggle got %0d/%b want %0d/%b",
                   c.name, fcnt, ftog, c.cnt, c.tog);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    clr    = 1'b0;
    chk_rd = 1'b0;
    chk_st = 1'b0;
  endtask

  task automatic exp_st(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    stq.push_back(e);
    chk_st = 1'b1;
  endtask

  task automatic exp_rd(input string n, input logic [1:0] a,
                        input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    rdq.push_back(e);
    raddr  = a;
    chk_rd = 1'b1;
  endtask

  task automatic exp_commit(input string n, input logic [15:0] c,
                            input logic t);
    cexp_t e;
    e.name = n;
    e.cnt  = c;
    e.tog  = t;
    cq.push_back(e);
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tick();
  endtask

  // Three plain beats then the TLAST beat, which must commit.
  task automatic good_frame(input string n, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [15:0] c,
                            input logic t);
    beat(w0, 1'b0);
    beat(w1, 1'b0);
    beat(w2, 1'b0);
    exp_commit(n, c, t);
    beat(w3, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    exp_st("rst_status", 32'h0);
    exp_rd("rst_rd", 2'd2, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    good_frame("f1", 32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 16'd1, 1'b1);
    exp_rd("f1_rd2", 2'd2, 32'h40400000);
    exp_st("f1_status", 32'h4);
    tick();
    exp_rd("f1_rd0", 2'd0, 32'h3F800000);
    tick();
    exp_rd("f1_rd3", 2'd3, 32'h40800000);
    tick();

    beat(32'h50000000, 1'b0);
    exp_st("short_status", 32'h5);
    beat(32'h50000001, 1'b1);
    exp_rd("short_rd2", 2'd2, 32'h40400000);
    tick();

    beat(32'h41000000, 1'b0);
    beat(32'h41100000, 1'b0);
    beat(32'h41200000, 1'b0);
    exp_commit("f2", 16'd2, 1'b0);
    exp_rd("commit_same_cycle", 2'd1, 32'h40000000);
    beat(32'h41300000, 1'b1);
    exp_rd("commit_next_cycle", 2'd1, 32'h41100000);
    exp_st("f2_status", 32'h5);
    tick();

    clr = 1'b1;
    exp_st("clear_1", 32'h4);
    tick();

    beat(32'h60000000, 1'b0);
    beat(32'h60000001, 1'b0);
    beat(32'h60000002, 1'b0);
    exp_st("long_missing", 32'h6);
    beat(32'h60000003, 1'b0);
    beat(32'h60000004, 1'b0);
    exp_st("long_discard", 32'h6);
    beat(32'h60000005, 1'b1);
    good_frame("f3", 32'h42000000, 32'h42100000, 32'h42200000,
               32'h42300000, 16'd3, 1'b1);
    exp_rd("f3_rd0", 2'd0, 32'h42000000);
    tick();
    exp_rd("f3_rd3", 2'd3, 32'h42300000);
    tick();

    beat(32'h70000000, 1'b0);
    clr = 1'b1;
    exp_st("clr_collision", 32'h5);
    beat(32'h70000001, 1'b1);
    clr = 1'b1;
    exp_st("clr_alone", 32'h4);
    exp_rd("collision_rd3", 2'd3, 32'h42300000);
    tick();

    beat(32'h43000000, 1'b0);
    beat(32'h43100000, 1'b0);
    tvalid = 1'b1;
    tdata  = 32'h43200000;
    tlast  = 1'b0;
    rst_n  = 1'b0;
    exp_st("rst_mid_status", 32'h0);
    exp_rd("rst_mid_rd", 2'd2, 32'h0);
    tick();
    exp_st("rst_hold_status", 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    good_frame("f_after_rst", 32'h43000000, 32'h43100000, 32'h43200000,
               32'h43300000, 16'd1, 1'b1);
    exp_rd("after_rst_rd2", 2'd2, 32'h43200000);
    tick();

    repeat (97) tick();
    exp_st("wd_pre", 32'h4);
    tick();
    exp_st("wd_stale", STALE_ST);
    exp_rd("wd_rd2", 2'd2, 32'h43200000);
    tick();

    beat(32'h44000000, 1'b0);
    beat(32'h44100000, 1'b0);
    beat(32'h44200000, 1'b0);
    exp_commit("f_wd", 16'd2, 1'b0);
    exp_st("wd_cleared", 32'h4);
    beat(32'h44300000, 1'b1);
    exp_rd("f_wd_rd1", 2'd1, 32'h44100000);
    tick();
    tick();
    tick();

    while (cq.size() != 0) begin
      cexp_t c;
      c = cq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: commit got none want count %0d", c.name, c.cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/setpoint_stream_rx.md
SETPOINT_STREAM_RX -- requirements
Module: setpoint_stream_rx

Interface
REQ-001 The block SHALL have the parameter RESULT_COUNT, default 32, giving the number of setpoints per frame (range 2..512).
REQ-002 The block SHALL have the parameter WATCHDOG_CYCLES, default 100000, giving the frame-timeout period in clk cycles.
REQ-003 The block SHALL use the local width AW = $clog2(RESULT_COUNT).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  the single clock; all logic rises on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these stream and readback ports:
- SETPOINT_TVALID  in  1  beat valid; the block is always ready and has no TREADY.
- SETPOINT_TLAST  in  1  last beat of a frame.
- SETPOINT_TDATA  in  32  setpoint word (IEEE-754 single).
- readAddress  in  AW  setpoint index to read back.
- readData  out  32  setpoint of the committed frame.
- statusClearStrobe  in  1  clears the sticky error flags.
- frameToggle  out  1  toggles on each committed frame.
- frameCount  out  16  count of committed frames, wrapping.
- status  out  32  {28'b0, stale, valid, tlastMissing, tlastUnexpected}.

Function
REQ-006 The block SHALL hold two RESULT_COUNT x 32 banks; beats SHALL be written to the inactive bank at index beatIndex, and reads SHALL come from the active bank.
REQ-007 The FSM SHALL have states RECEIVE and DISCARD and SHALL leave reset in RECEIVE with beatIndex=0.
REQ-008 In RECEIVE, a beat with TLAST=0 and beatIndex<RESULT_COUNT-1 SHALL store the word and increment beatIndex.
REQ-009 In RECEIVE, a beat with TLAST=1 and beatIndex==RESULT_COUNT-1 SHALL commit the frame, and all effects SHALL occur on the cycle after the beat:
- store the word;
- flip the active bank;
- toggle frameToggle;
- increment frameCount, wrapping 0xFFFF->0;
- set valid=1;
- set beatIndex=0.
REQ-010 In RECEIVE, a beat with TLAST=1 and beatIndex<RESULT_COUNT-1 SHALL discard the frame, with no bank flip, and SHALL set tlastUnexpected and beatIndex=0.
REQ-011 In RECEIVE, a beat with TLAST=0 and beatIndex==RESULT_COUNT-1 SHALL discard the frame, set tlastMissing, and enter DISCARD.
REQ-012 In DISCARD, the block SHALL ignore beats until a beat with TLAST=1, then SHALL return to RECEIVE with beatIndex=0.
REQ-013 Cycles with TVALID=0 SHALL change no state, except the watchdog.
REQ-014 readData SHALL be registered with 1-cycle latency from readAddress.
REQ-015 readData SHALL be 0 while valid=0 or when readAddress>=RESULT_COUNT.
REQ-016 A read in the same cycle as a commit SHALL return the pre-commit bank; the read on the next cycle SHALL return the new bank.
REQ-017 tlastMissing and tlastUnexpected SHALL be sticky and SHALL be cleared by statusClearStrobe.
REQ-018 When an error and statusClearStrobe coincide in a cycle, the error SHALL win and the flag SHALL be 1.

Reset
REQ-019 While rst_n=0, the block SHALL drive readData=0, frameToggle=0, frameCount=0 and status=0.
REQ-020 While rst_n=0, the block SHALL hold the FSM in RECEIVE with beatIndex=0, the active bank at 0, and the watchdog counter at 0.
REQ-021 Bank contents SHALL NOT be reset; valid=0 SHALL mask them.
REQ-022 A reset mid-frame SHALL drop the partial frame; the first beat after reset release SHALL be treated as index 0.

Configuration
REQ-023 The macro SETPOINT_RX_WATCHDOG_EN SHALL select the frame-timeout watchdog.
REQ-024 With SETPOINT_RX_WATCHDOG_EN defined, a counter SHALL behave as follows:
- it clears on each commit;
- otherwise it increments, saturating at WATCHDOG_CYCLES;
- stale SHALL be 1 while the counter equals WATCHDOG_CYCLES;
- stale SHALL NOT clear readData.
REQ-025 Without SETPOINT_RX_WATCHDOG_EN, stale SHALL be constant 0 and no watchdog counter SHALL be present.

Verification (RESULT_COUNT=4, WATCHDOG_CYCLES=100)
REQ-026 Good frame: 4 beats 0x3F800000..0x40800000, TLAST on beat 4. Required response:
- frameToggle 0->1 and frameCount=1 one cycle after the last beat;
- readAddress=2 gives readData=0x40400000 one cycle later.
REQ-027 Short frame: TLAST on beat 2. Required response:
- tlastUnexpected=1;
- frameCount unchanged and readData unchanged;
- the next good 4-beat frame commits with frameCount+1.
REQ-028 Long frame: 6 beats, TLAST on beat 6. Required response:
- tlastMissing=1 after beat 4;
- beats 5-6 are ignored and there is no commit;
- the following good frame commits.
REQ-029 Reset during beat 3, then a good frame. Required response:
- status=0 and readData=0 during reset;
- after release, 4 beats commit with frameCount=1.
REQ-030 Clear collision: statusClearStrobe in the same cycle as an unexpected-TLAST beat; tlastUnexpected=1 is required. A clear alone on the following cycle SHALL give 0.
REQ-031 Watchdog, with SETPOINT_RX_WATCHDOG_EN defined:
- 100 idle cycles after a commit, stale=1;
- readData is retained;
- the next commit gives stale=0 one cycle later.
